writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter LQ_DEPTH, default 2, SHALL set the number of outstanding loads (power of two, >=2).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 alu_valid/alu_ready  in/out  1/1  ALU result handshake.
REQ-005 alu_rd, alu_result  in  5/32  ALU destination and value.
REQ-006 ld_issue/ld_ready  in/out  1/1  load-issue handshake.
REQ-007 ld_rd, ld_funct3, ld_addr_lo  in  5/3/2  load destination, RV32I load funct3 and byte offset.
REQ-008 mem_rvalid/mem_rready  in/out  1/1  memory read-data handshake; mem_rdata  in  32  word-aligned data.
REQ-009 rs1_addr, rs2_addr  in  5/5  decode-stage source registers; hazard  out  1  stall request.
REQ-010 wr_en, wr_addr, wdata  out  1/5/32  register-file write port, registered.
REQ-011 ld_busy  out  1  at least one load outstanding.

Function
REQ-012 A 32-bit pending bitmap SHALL track registers awaiting load data; bit 0 SHALL always read 0.
REQ-013 ld_ready SHALL be 1 only when the load queue is not full and pending[ld_rd] is 0.
REQ-014 On ld_issue&ld_ready, {ld_rd, ld_funct3, ld_addr_lo} SHALL be pushed in order; pending[ld_rd] SHALL be set at that edge unless ld_rd is 0.
REQ-015 mem_rready SHALL equal "queue not empty"; mem_rvalid with an empty queue SHALL be ignored.
REQ-016 On mem_rvalid&mem_rready, the queue head SHALL be popped and its result written: wr_en=1, wr_addr=head rd, wdata=extended data on the next cycle (1-cycle latency).
REQ-017 Extension: LB/LH sign-extend, LBU/LHU zero-extend the byte/halfword at lane ld_addr_lo (LH/LHU use ld_addr_lo[1]); LW passes mem_rdata; reserved funct3 (011,110,111) SHALL be treated as LW.
REQ-018 alu_ready SHALL be 0 in any cycle where mem_rvalid&mem_rready is 1 (load data has priority); otherwise 1.
REQ-019 On alu_valid&alu_ready, the unit SHALL write alu_rd/alu_result with the same 1-cycle latency.
REQ-020 Writes with destination 0 SHALL keep wr_en=0.
REQ-021 pending[rd] SHALL clear at the edge ending the cycle in which wr_en=1 for that load write, so the register file holds the value before the stall drops.
REQ-022 hazard SHALL be 1 when pending[rs1_addr] or pending[rs2_addr] is 1, or when alu_valid and pending[alu_rd] is 1 (WAW); while hazard from WAW is 1, alu_ready SHALL be 0.
REQ-023 Simultaneous issue to rd X and retire of rd X: issue SHALL be refused that cycle (REQ-013), with no bitmap corruption.
REQ-024 Simultaneous push and pop on a full queue SHALL NOT occur (ld_ready=0 when full); on a non-full, non-empty queue both SHALL take effect.
REQ-025 ld_busy SHALL equal "queue not empty".

Reset
REQ-026 While reset=1: queue empty, pending=0, wr_en=0, wr_addr=0, wdata=0, ld_ready=0, alu_ready=0, mem_rready=0, hazard=0.
REQ-027 Reset asserted mid-operation SHALL discard all outstanding loads; memory responses arriving after reset for discarded loads SHALL be ignored (empty queue).

Structure
REQ-028 Load funct3 encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101) and the register-index width SHALL live in shared package rv32_pkg.
REQ-029 Byte-lane selection and extension SHALL be a combinational sub-module load_align.

Verification
REQ-030 Issue LB x5, addr_lo=3; respond mem_rdata=0x80FF_0000 -> next cycle wr_en=1, wr_addr=5, wdata=0xFFFF_FF80.
REQ-031 Issue LHU x6, addr_lo=2, rdata=0x9ABC_1234 -> wdata=0x0000_9ABC; rs1_addr=6 -> hazard=1 from issue through the wr_en cycle, 0 the cycle after.
REQ-032 alu_valid (x7=0x11) same cycle as mem_rvalid for x8 -> alu_ready=0; x8 written first, x7 written the following cycle.
REQ-033 Two loads x1, x2 issued back-to-back -> ld_ready=0 (full); retire order x1 then x2; third issue to x1 refused until x1's write commits.
REQ-034 ALU write to x0 and load to x0 -> wr_en stays 0, hazard never asserted.
REQ-035 Reset pulsed with one load outstanding, then mem_rvalid=1 -> no write, ld_busy=0, pending=0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the writeback path: load funct3 encodings,
// register-index width and the load-queue entry layout.
package rv32_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [2:0]           funct3;
    logic [1:0]           addr_lo;
  } lq_entry_t;

endpackage

// File: rtl/load_align.sv
// Byte/halfword lane selection and sign/zero extension of a word-aligned
// memory read according to the RV32I load funct3.
module load_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'h0, byte_sel};
      F3_LHU:  data = {16'h0, half_sel};
      default: data = rdata;  // LW and the reserved encodings
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: merges ALU results with in-order load
// returns, tracks registers awaiting load data and raises decode hazards.
module writeback_unit
  import rv32_pkg::*;
#(
  parameter int LQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [31:0]          alu_result,
  input  logic                 ld_issue,
  output logic                 ld_ready,
  input  logic [REG_IDX_W-1:0] ld_rd,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_addr_lo,
  input  logic                 mem_rvalid,
  output logic                 mem_rready,
  input  logic [31:0]          mem_rdata,
  input  logic [REG_IDX_W-1:0] rs1_addr,
  input  logic [REG_IDX_W-1:0] rs2_addr,
  output logic                 hazard,
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_addr,
  output logic [31:0]          wdata,
  output logic                 ld_busy
);

  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lq_entry_t            lq_mem [LQ_DEPTH];
  lq_entry_t            head;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [31:0]          pending, pending_nxt;
  logic                 lq_empty, lq_full;
  logic                 ld_fire, mem_fire, alu_fire, waw;
  logic                 clr_en;
  logic [REG_IDX_W-1:0] clr_rd;
  logic [31:0]          ld_data;

  assign lq_empty   = (count == '0);
  assign lq_full    = (count == CNT_W'(LQ_DEPTH));
  assign head       = lq_mem[rd_ptr];
  assign waw        = alu_valid & pending[alu_rd];

  assign ld_ready   = !reset && !lq_full && !pending[ld_rd];
  assign mem_rready = !reset && !lq_empty;
  assign mem_fire   = mem_rvalid & mem_rready;
  assign alu_ready  = !reset && !mem_fire && !waw;
  assign alu_fire   = alu_valid & alu_ready;
  assign ld_fire    = ld_issue & ld_ready;
  assign hazard     = !reset && (pending[rs1_addr] || pending[rs2_addr] || waw);
  assign ld_busy    = !reset && !lq_empty;

  load_align u_align (
    .funct3  (head.funct3),
    .addr_lo (head.addr_lo),
    .rdata   (mem_rdata),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (ld_fire) lq_mem[wr_ptr] <= '{rd: ld_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (ld_fire)  wr_ptr <= wr_ptr + 1'b1;
      if (mem_fire) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(ld_fire) - CNT_W'(mem_fire);
    end
  end

  // The pending bit drops one edge after the load write is presented, so
  // the register file already holds the value when the stall releases.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_rd] = 1'b0;
    if (ld_fire && ld_rd != '0) pending_nxt[ld_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      clr_en  <= 1'b0;
      clr_rd  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wdata   <= '0;
    end else begin
      pending <= pending_nxt;
      clr_en  <= mem_fire;
      clr_rd  <= head.rd;
      if (mem_fire) begin
        wr_en   <= (head.rd != '0);
        wr_addr <= head.rd;
        wdata   <= ld_data;
      end else if (alu_fire) begin
        wr_en   <= (alu_rd != '0);
        wr_addr <= alu_rd;
        wdata   <= alu_result;
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: load extension, hazards, ALU/load
// arbitration, queue full/order, x0 handling and reset discard.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_issue, ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid, mem_rready;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        hazard, wr_en, ld_busy;
  logic [4:0]  wr_addr;
  logic [31:0] wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_unit #(.LQ_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_issue(ld_issue), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
    .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata), .ld_busy(ld_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge; checks run 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    ld_issue = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d;
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_issue = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0;
    mem_rvalid = 0; mem_rdata = 0; rs1_addr = 0; rs2_addr = 0;

    // reset state, with requests present
    next_cycle();
    alu_valid = 1; alu_rd = 3; issue(5'd4, 3'b010, 2'd0); respond(32'h1234_5678);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_rready", mem_rready, 0);
    check("rst_hazard", hazard, 0);
    check("rst_ld_busy", ld_busy, 0);
    next_cycle();
    alu_valid = 0; ld_issue = 0; mem_rvalid = 0;
    reset = 0;

    // LB x5, lane 3, negative byte
    next_cycle();
    issue(5'd5, 3'b000, 2'd3); #1;
    check("a_ld_ready", ld_ready, 1);
    next_cycle();
    ld_issue = 0; rs1_addr = 5; respond(32'h80FF_0000); #1;
    check("a_busy", ld_busy, 1);
    check("a_mem_rready", mem_rready, 1);
    check("a_hazard_wait", hazard, 1);
    check("a_alu_ready_blk", alu_ready, 0);
    next_cycle();
    mem_rvalid = 0;
    check("a_wr_en", wr_en, 1);
    check("a_wr_addr", wr_addr, 5);
    check("a_wdata", wdata, 32'hFFFF_FF80);
    check("a_hazard_wr", hazard, 1);
    check("a_busy_done", ld_busy, 0);
    next_cycle();
    check("a_wr_en_off", wr_en, 0);
    check("a_hazard_off", hazard, 0);
    rs1_addr = 0;

    // LHU x6, lane 2; hazard window on rs1
    next_cycle();
    issue(5'd6, 3'b101, 2'd2); rs1_addr = 6;
    next_cycle();
    ld_issue = 0;
    check("b_hazard_1", hazard, 1);
    next_cycle();
    check("b_hazard_2", hazard, 1);
    respond(32'h9ABC_1234);
    next_cycle();
    mem_rvalid = 0;
    check("b_wr_en", wr_en, 1);
    check("b_wr_addr", wr_addr, 6);
    check("b_wdata", wdata, 32'h0000_9ABC);
    check("b_hazard_wr", hazard, 1);
    next_cycle();
    check("b_hazard_off", hazard, 0);
    check("b_wr_en_off", wr_en, 0);
    rs1_addr = 0;

    // ALU x7 collides with load data for x8
    next_cycle();
    issue(5'd8, 3'b010, 2'd0);
    next_cycle();
    ld_issue = 0; respond(32'hDEAD_BEEF);
    alu_valid = 1; alu_rd = 7; alu_result = 32'h11; #1;
    check("c_alu_ready_blk", alu_ready, 0);
    next_cycle();
    mem_rvalid = 0; #1;
    check("c_wr_addr_ld", wr_addr, 8);
    check("c_wdata_ld", wdata, 32'hDEAD_BEEF);
    check("c_alu_ready", alu_ready, 1);
    next_cycle();
    alu_valid = 0;
    check("c_wr_en_alu", wr_en, 1);
    check("c_wr_addr_alu", wr_addr, 7);
    check("c_wdata_alu", wdata, 32'h11);
    next_cycle();
    check("c_wr_en_off", wr_en, 0);

    // two loads fill the queue; re-issue to x1 waits; push+pop together
    issue(5'd1, 3'b010, 2'd0); #1;
    check("d_ready_1", ld_ready, 1);
    next_cycle();
    issue(5'd2, 3'b100, 2'd1); #1;
    check("d_ready_2", ld_ready, 1);
    next_cycle();
    issue(5'd1, 3'b111, 2'd0); respond(32'h0000_AB00); #1;
    check("d_full", ld_ready, 0);
    check("d_busy", ld_busy, 1);
    next_cycle();
    mem_rvalid = 0; #1;
    check("d_wr_addr_x1", wr_addr, 1);
    check("d_wdata_x1", wdata, 32'h0000_AB00);
    check("d_ready_pend", ld_ready, 0);
    next_cycle();
    respond(32'h0000_AB00); #1;
    check("d_ready_after", ld_ready, 1);
    next_cycle();
    ld_issue = 0; respond(32'h1234_5678);
    check("d_wr_addr_x2", wr_addr, 2);
    check("d_wdata_x2", wdata, 32'h0000_00AB);
    check("d_busy_mid", ld_busy, 1);
    next_cycle();
    mem_rvalid = 0; #1;
    check("d_wr_addr_x1b", wr_addr, 1);
    check("d_wdata_x1b", wdata, 32'h1234_5678);
    check("d_busy_end", ld_busy, 0);
    next_cycle();

    // destination x0 for ALU and load
    alu_valid = 1; alu_rd = 0; alu_result = 32'h55; #1;
    check("e_alu_ready", alu_ready, 1);
    check("e_hazard_alu", hazard, 0);
    next_cycle();
    alu_valid = 0; issue(5'd0, 3'b010, 2'd0); #1;
    check("e_wr_en_alu", wr_en, 0);
    check("e_ld_ready", ld_ready, 1);
    next_cycle();
    ld_issue = 0; respond(32'hFFFF_FFFF); #1;
    check("e_hazard_ld", hazard, 0);
    next_cycle();
    mem_rvalid = 0; #1;
    check("e_wr_en_ld", wr_en, 0);
    check("e_hazard_end", hazard, 0);
    next_cycle();

    // WAW: ALU to a register still awaiting load data
    issue(5'd11, 3'b010, 2'd0);
    next_cycle();
    ld_issue = 0; alu_valid = 1; alu_rd = 11; alu_result = 32'h22; #1;
    check("g_waw_hazard", hazard, 1);
    check("g_waw_alu_ready", alu_ready, 0);
    next_cycle();
    respond(32'h0000_0077);
    next_cycle();
    mem_rvalid = 0; #1;
    check("g_wdata_ld", wdata, 32'h0000_0077);
    check("g_alu_ready_wr", alu_ready, 0);
    next_cycle();
    check("g_alu_ready", alu_ready, 1);
    check("g_hazard_off", hazard, 0);
    next_cycle();
    alu_valid = 0;
    check("g_wr_addr_alu", wr_addr, 11);
    check("g_wdata_alu", wdata, 32'h22);
    next_cycle();

    // LH sign extension on the upper halfword
    issue(5'd10, 3'b001, 2'd2);
    next_cycle();
    ld_issue = 0; respond(32'h8001_1234);
    next_cycle();
    mem_rvalid = 0; #1;
    check("h_wdata", wdata, 32'hFFFF_8001);
    next_cycle();

    // reset discards an outstanding load; late response ignored
    issue(5'd9, 3'b001, 2'd2);
    next_cycle();
    ld_issue = 0; reset = 1; rs1_addr = 9; #1;
    check("f_hazard_rst", hazard, 0);
    next_cycle();
    reset = 0; respond(32'hCAFE_F00D); ld_rd = 9; #1;
    check("f_mem_rready", mem_rready, 0);
    check("f_busy", ld_busy, 0);
    check("f_hazard", hazard, 0);
    check("f_ld_ready", ld_ready, 1);
    next_cycle();
    mem_rvalid = 0; #1;
    check("f_wr_en", wr_en, 0);
    rs1_addr = 0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
